// File: rtl/timer_ctrl_if.sv
// Button/sensor inputs and counter/heater outputs of the cook timer, bundled.
// Latency: none, wiring only.
// Backpressure: none, level signals and one-cycle strobes.
interface timer_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic       door_closed;
    logic       zero_all;
    logic       cnt_loadn;
    logic       cnt_clrn;
    logic       cnt_en;
    logic       mag_on;
    logic       done;
    logic       alarm;
    logic [2:0] state_o;

    // Panel/sensor side: drives buttons and sensors, observes controller outputs
    modport master (
        output start, stop, clear, load, door_closed, zero_all,
        input  cnt_loadn, cnt_clrn, cnt_en, mag_on, done, alarm, state_o
    );

    // Controller side
    modport slave (
        input  start, stop, clear, load, door_closed, zero_all,
        output cnt_loadn, cnt_clrn, cnt_en, mag_on, done, alarm, state_o
    );
endinterface

// File: rtl/timer_ctrl.sv
// Cook-timer control FSM (IDLE/RUN/PAUSE/DONE) with tick prescaler and digit-counter strobes.
// Latency: all outputs registered; a button edge gets its response one cycle after detection.
// Backpressure: none; events are single-cycle and dropped if outranked in the same cycle.
// Option: define TIMER_CTRL_ALARM_EN to drive a toggling alarm in DONE (otherwise alarm is tied 0).
module timer_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        clrn,
    timer_ctrl_if.slave tif
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_arm;
    logic          r_start_q;
    logic          r_stop_q;
    logic          r_clear_q;
    logic          r_load_q;
    logic          r_cnt_loadn;
    logic          r_cnt_clrn;
    logic          r_cnt_en;
    logic          r_mag_on;
    logic          r_done;

    logic          w_start_ev;
    logic          w_stop_ev;
    logic          w_clear_ev;
    logic          w_load_ev;
    logic          w_halt;
    logic          w_wrap;
    logic [PW-1:0] w_presc_nxt;

    // Edge-detect history; r_arm masks events in the first cycle after reset so a
    // button already held through reset release is absorbed rather than acted on.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_arm     <= 1'b0;
            r_start_q <= 1'b0;
            r_stop_q  <= 1'b0;
            r_clear_q <= 1'b0;
            r_load_q  <= 1'b0;
        end else begin
            r_arm     <= 1'b1;
            r_start_q <= tif.start;
            r_stop_q  <= tif.stop;
            r_clear_q <= tif.clear;
            r_load_q  <= tif.load;
        end
    end

    assign w_start_ev  = r_arm & tif.start & ~r_start_q;
    assign w_stop_ev   = r_arm & tif.stop  & ~r_stop_q;
    assign w_clear_ev  = r_arm & tif.clear & ~r_clear_q;
    assign w_load_ev   = r_arm & tif.load  & ~r_load_q;
    // Open door counts as a pause request and ranks with stop.
    assign w_halt      = w_stop_ev | ~tif.door_closed;
    assign w_wrap      = (r_presc == PRESC_MAX);
    assign w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);

`ifdef TIMER_CTRL_ALARM_EN
    logic r_alarm;
    assign tif.alarm = r_alarm;
`else
    assign tif.alarm = 1'b0;
`endif

    // Main FSM: priority clear > halt (stop/door open) > start > load; strobes default inactive
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_cnt_loadn <= 1'b1;
            r_cnt_clrn  <= 1'b1;
            r_cnt_en    <= 1'b0;
            r_mag_on    <= 1'b0;
            r_done      <= 1'b0;
`ifdef TIMER_CTRL_ALARM_EN
            r_alarm     <= 1'b0;
`endif
        end else begin
            r_cnt_loadn <= 1'b1;
            r_cnt_clrn  <= 1'b1;
            r_cnt_en    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (w_clear_ev) begin
                        r_cnt_clrn <= 1'b0;
                    end else if (w_halt) begin
                        // stop/door open outranks start and load; nothing to do in IDLE
                    end else if (w_start_ev) begin
                        if (!tif.zero_all) begin
                            r_state  <= S_RUN;
                            r_mag_on <= 1'b1;
                        end
                    end else if (w_load_ev) begin
                        r_cnt_loadn <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_clear_ev) begin
                        r_state    <= S_IDLE;
                        r_cnt_clrn <= 1'b0;
                        r_presc    <= '0;
                        r_mag_on   <= 1'b0;
                    end else if (w_halt) begin
                        // prescaler held so a resume finishes the partial tick
                        r_state  <= S_PAUSE;
                        r_mag_on <= 1'b0;
                    end else begin
                        r_presc <= w_presc_nxt;
                        if (tif.zero_all) begin
                            r_state  <= S_DONE;
                            r_mag_on <= 1'b0;
                            r_done   <= 1'b1;
`ifdef TIMER_CTRL_ALARM_EN
                            r_alarm  <= 1'b1;
`endif
                        end else if (w_wrap) begin
                            r_cnt_en <= 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (w_clear_ev) begin
                        r_state    <= S_IDLE;
                        r_cnt_clrn <= 1'b0;
                        r_presc    <= '0;
                    end else if (w_halt) begin
                        // stay paused
                    end else if (w_start_ev) begin
                        r_state  <= S_RUN;
                        r_mag_on <= 1'b1;
                    end
                end
                S_DONE: begin
                    // prescaler keeps running here to pace the alarm
                    r_presc <= w_presc_nxt;
`ifdef TIMER_CTRL_ALARM_EN
                    if (w_wrap) begin
                        r_alarm <= ~r_alarm;
                    end
`endif
                    if (w_clear_ev || (!w_halt && !w_start_ev && w_load_ev)) begin
                        r_state     <= S_IDLE;
                        r_presc     <= '0;
                        r_done      <= 1'b0;
                        r_cnt_clrn  <= ~w_clear_ev;
                        r_cnt_loadn <= w_clear_ev;
`ifdef TIMER_CTRL_ALARM_EN
                        r_alarm     <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_presc  <= '0;
                    r_mag_on <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign tif.state_o   = r_state;
    assign tif.cnt_loadn = r_cnt_loadn;
    assign tif.cnt_clrn  = r_cnt_clrn;
    assign tif.cnt_en    = r_cnt_en;
    assign tif.mag_on    = r_mag_on;
    assign tif.done      = r_done;
endmodule

// File: tb/tb_timer_ctrl.sv
// Scripted bench for timer_ctrl with TICK_DIV=4: expected output vectors are queued
// against a target cycle when stimulus is driven and compared on the falling edge.
module tb_timer_ctrl;
    logic clk;
    logic clrn;
    int   cyc;
    int   n_vec;
    int   n_err;

    timer_ctrl_if tif();

    timer_ctrl #(.TICK_DIV(4)) u_dut (
        .clk  (clk),
        .clrn (clrn),
        .tif  (tif)
    );

`ifdef TIMER_CTRL_ALARM_EN
    localparam bit ALM = 1'b1;
`else
    localparam bit ALM = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // {state_o, cnt_loadn, cnt_clrn, cnt_en, mag_on, done, alarm}
    function automatic logic [8:0] v(input logic [2:0] st, input bit ld, input bit cl,
                                     input bit en, input bit mg, input bit dn, input bit al);
        return {st, ld, cl, en, mg, dn, al};
    endfunction

    function automatic logic [8:0] obs();
        return {tif.state_o, tif.cnt_loadn, tif.cnt_clrn, tif.cnt_en,
                tif.mag_on, tif.done, tif.alarm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got[8:0], exp[8:0]);
        end
    endtask

    task automatic exp_at(input int dc, input logic [8:0] vec, input string tag);
        exp_t x;
        x.cyc = cyc + dc;
        x.vec = vec;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare every entry due this cycle, away from the rising edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, 32'(obs()), 32'(e.vec));
        end
    end

    logic [8:0] IDLE_V, RUN_V, RUNEN_V, PAUSE_V, CLR_V, LOAD_V;

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        IDLE_V  = v(3'd0, 1, 1, 0, 0, 0, 0);
        RUN_V   = v(3'd1, 1, 1, 0, 1, 0, 0);
        RUNEN_V = v(3'd1, 1, 1, 1, 1, 0, 0);
        PAUSE_V = v(3'd2, 1, 1, 0, 0, 0, 0);
        CLR_V   = v(3'd0, 1, 0, 0, 0, 0, 0);
        LOAD_V  = v(3'd0, 0, 1, 0, 0, 0, 0);
        clrn = 1'b0;
        tif.start = 1'b0; tif.stop = 1'b0; tif.clear = 1'b0; tif.load = 1'b0;
        tif.door_closed = 1'b1; tif.zero_all = 1'b0;

        tick(2);                                  // c2
        exp_at(0, IDLE_V, "reset");
        clrn = 1'b1;
        tick(1);                                  // c3: load press, held two edges
        tif.load = 1'b1;
        exp_at(1, LOAD_V, "load_pulse");
        exp_at(2, IDLE_V, "load_once");
        tick(2);                                  // c5: start
        tif.load = 1'b0;
        tif.start = 1'b1;
        exp_at(1, RUN_V,   "run_entry");
        exp_at(2, RUN_V,   "run_p1");
        exp_at(4, RUN_V,   "run_pre_tick");
        exp_at(5, RUNEN_V, "run_tick1");
        exp_at(6, RUN_V,   "run_tick1_once");
        exp_at(8, RUN_V,   "run_p3");
        tick(1);                                  // c6
        tif.start = 1'b0;
        tick(7);                                  // c13: prescaler at wrap, raise zero_all
        tif.zero_all = 1'b1;
        exp_at(1, v(3'd3, 1, 1, 0, 0, 1, ALM), "done_entry_no_en");
        exp_at(4, v(3'd3, 1, 1, 0, 0, 1, ALM), "alarm_hold");
        exp_at(5, v(3'd3, 1, 1, 0, 0, 1, 0),   "alarm_tog0");
        exp_at(8, v(3'd3, 1, 1, 0, 0, 1, 0),   "alarm_low_hold");
        exp_at(9, v(3'd3, 1, 1, 0, 0, 1, ALM), "alarm_tog1");
        tick(2);                                  // c15: stop ignored in DONE
        tif.stop = 1'b1;
        tick(1);
        tif.stop = 1'b0;
        tick(3);                                  // c19: start ignored in DONE
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
        tick(2);                                  // c22: load leaves DONE
        tif.load = 1'b1;
        exp_at(1, LOAD_V, "done_load");
        exp_at(2, IDLE_V, "done_load_idle");
        tick(1);                                  // c23
        tif.load = 1'b0;
        tif.zero_all = 1'b0;
        tick(1);                                  // c24: run again
        tif.start = 1'b1;
        exp_at(1, RUN_V, "rerun");
        exp_at(3, RUN_V, "rerun_p2");
        tick(1);
        tif.start = 1'b0;
        tick(2);                                  // c27: prescaler=2, open door
        tif.door_closed = 1'b0;
        exp_at(1, PAUSE_V, "door_pause");
        exp_at(2, PAUSE_V, "door_pause_hold");
        tick(2);                                  // c29: close door and resume
        tif.door_closed = 1'b1;
        tif.start = 1'b1;
        exp_at(1, RUN_V,   "resume");
        exp_at(2, RUN_V,   "resume_p3");
        exp_at(3, RUNEN_V, "resume_tick");
        exp_at(4, RUN_V,   "resume_tick_once");
        tick(1);
        tif.start = 1'b0;
        tick(3);                                  // c33: stop button
        tif.stop = 1'b1;
        exp_at(1, PAUSE_V, "stop_pause");
        exp_at(2, PAUSE_V, "stop_pause_hold");
        tick(1);
        tif.stop = 1'b0;
        tick(1);                                  // c35: clear and start together
        tif.clear = 1'b1;
        tif.start = 1'b1;
        exp_at(1, CLR_V,  "clr_over_start");
        exp_at(2, IDLE_V, "clr_once");
        tick(1);
        tif.clear = 1'b0;
        tif.start = 1'b0;
        tick(1);                                  // c37: clear in IDLE
        tif.clear = 1'b1;
        exp_at(1, CLR_V,  "clr_idle");
        exp_at(2, IDLE_V, "clr_idle_once");
        tick(1);
        tif.clear = 1'b0;
        tick(1);                                  // c39: start with zero_all=1 ignored
        tif.zero_all = 1'b1;
        tif.start = 1'b1;
        exp_at(1, IDLE_V, "start_zero_ign");
        exp_at(2, IDLE_V, "start_zero_ign2");
        tick(1);
        tif.start = 1'b0;
        tif.zero_all = 1'b0;
        tick(1);                                  // c41: start and keep holding
        tif.start = 1'b1;
        exp_at(1, RUN_V, "hold_run");
        exp_at(2, RUN_V, "hold_run2");
        tick(2);                                  // c43: reset one edge mid-RUN
        clrn = 1'b0;
        exp_at(1, IDLE_V, "rst_midrun");
        tick(1);                                  // c44: release with start still high
        clrn = 1'b1;
        exp_at(1, IDLE_V, "rst_held_start1");
        exp_at(2, IDLE_V, "rst_held_start2");
        exp_at(3, IDLE_V, "rst_held_start3");
        tick(3);
        tif.start = 1'b0;
        tick(3);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
